// File: rtl/dmi_router.sv
// dmi_router: steers DMI requests to one of NUM_TGT register targets by address window, lowest index wins.
// Latency: error T+1, write T+2, read T+2+RD_LAT. One request in flight; req_ready stays low while busy.

module dmi_router #(
   parameter int NUM_TGT = 4,
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 32,
   parameter int RD_LAT  = 1,
   parameter logic [NUM_TGT*ADDR_W-1:0] TGT_BASE = {7'h70, 7'h60, 7'h40, 7'h00},
   parameter logic [NUM_TGT*ADDR_W-1:0] TGT_MASK = {7'h70, 7'h70, 7'h60, 7'h40}
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_wr,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [DATA_W-1:0]         req_wdata,
   output logic                      resp_valid,
   output logic                      resp_err,
   output logic [DATA_W-1:0]         resp_rdata,
   input  logic [NUM_TGT-1:0]        tgt_enable,
   output logic [NUM_TGT-1:0]        tgt_en,
   output logic                      tgt_wr_en,
   output logic [ADDR_W-1:0]         tgt_addr,
   output logic [DATA_W-1:0]         tgt_wdata,
   input  logic [NUM_TGT*DATA_W-1:0] tgt_rdata,
   output logic [7:0]                err_cnt,
   input  logic                      err_cnt_clr
);

   localparam int SEL_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t             state;
   req_t               tgt_q;
   logic [SEL_W-1:0]   hit_sel;
   logic [SEL_W-1:0]   sel;
   logic               hit_any;
   logic               sel_ok;
   logic               accept;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  sel_rdata;

   assign accept    = req_valid & req_ready;
   assign tgt_wr_en = tgt_q.wr;
   assign tgt_addr  = tgt_q.addr;
   assign tgt_wdata = tgt_q.wdata;
   assign sel_rdata = tgt_rdata[int'(sel)*DATA_W +: DATA_W];

   // Scan from the top so the lowest matching index is the one left standing.
   always_comb begin
      hit_any = 1'b0;
      hit_sel = '0;
      for (int i = NUM_TGT-1; i >= 0; i--) begin
         if ((req_addr & TGT_MASK[i*ADDR_W +: ADDR_W]) == TGT_BASE[i*ADDR_W +: ADDR_W]) begin
            hit_any = 1'b1;
            hit_sel = SEL_W'(i);
         end
      end
      sel_ok = hit_any & tgt_enable[hit_sel];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         tgt_en     <= '0;
         tgt_q      <= '0;
         sel        <= '0;
         cnt        <= '0;
         err_cnt    <= '0;
      end else begin
         resp_valid <= 1'b0;
         tgt_en     <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  tgt_q     <= {req_wr, req_addr, req_wdata};
                  sel       <= hit_sel;
                  req_ready <= 1'b0;
                  if (sel_ok) begin
                     tgt_en <= NUM_TGT'(1) << hit_sel;
                     state  <= ISSUE;
                  end else begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                     state      <= RESP;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            ISSUE: begin
               if (tgt_q.wr) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= '0;
                  state      <= RESP;
               end else begin
                  cnt   <= '0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               // Last WAIT cycle is the one where the target's data is valid.
               if (cnt == CNT_W'(RD_LAT-1)) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= sel_rdata;
                  state      <= RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (err_cnt_clr)
            err_cnt <= '0;
         else if (accept && !sel_ok && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_dmi_router.sv
// Randomized scoreboard bench for dmi_router: a range-based reference model predicts downstream strobes and
// responses with their cycles; a second instance (RD_LAT=4, overlapping windows) covers priority and mid-read reset.

module tb_dmi_router;

   localparam int NT = 4, AW = 7, DW = 32, LAT = 1, LAT_B = 4;
   localparam logic [NT*AW-1:0] BASE   = {7'h70, 7'h60, 7'h40, 7'h00};
   localparam logic [NT*AW-1:0] MASK   = {7'h70, 7'h70, 7'h60, 7'h40};
   localparam logic [NT*AW-1:0] BASE_B = {7'h70, 7'h70, 7'h40, 7'h00};
   localparam logic [NT*AW-1:0] MASK_B = {7'h70, 7'h7C, 7'h60, 7'h40};

   logic           clk, rst, req_valid, req_ready, req_wr, resp_valid, resp_err, tgt_wr_en, err_cnt_clr;
   logic [AW-1:0]  req_addr, tgt_addr;
   logic [DW-1:0]  req_wdata, resp_rdata, tgt_wdata;
   logic [NT-1:0]  tgt_enable, tgt_en;
   logic [NT*DW-1:0] tgt_rdata;
   logic [7:0]     err_cnt;

   logic           rst_b, req_valid_b, req_ready_b, resp_valid_b, resp_err_b, tgt_wr_en_b;
   logic [AW-1:0]  tgt_addr_b;
   logic [DW-1:0]  resp_rdata_b, tgt_wdata_b;
   logic [NT-1:0]  tgt_en_b;
   logic [NT*DW-1:0] tgt_rdata_b;
   logic [7:0]     err_cnt_b;

   dmi_router #(.NUM_TGT(NT), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .TGT_BASE(BASE), .TGT_MASK(MASK)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_rdata(resp_rdata), .tgt_enable(tgt_enable), .tgt_en(tgt_en), .tgt_wr_en(tgt_wr_en),
      .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata), .tgt_rdata(tgt_rdata), .err_cnt(err_cnt),
      .err_cnt_clr(err_cnt_clr));

   dmi_router #(.NUM_TGT(NT), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_B), .TGT_BASE(BASE_B), .TGT_MASK(MASK_B)) u_dut_b (
      .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_b), .resp_err(resp_err_b),
      .resp_rdata(resp_rdata_b), .tgt_enable(tgt_enable), .tgt_en(tgt_en_b), .tgt_wr_en(tgt_wr_en_b),
      .tgt_addr(tgt_addr_b), .tgt_wdata(tgt_wdata_b), .tgt_rdata(tgt_rdata_b), .err_cnt(err_cnt_b),
      .err_cnt_clr(err_cnt_clr));

   typedef struct { bit err; logic [DW-1:0] rdata; int cyc; } resp_exp_t;
   typedef struct { logic [NT-1:0] en; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; int cyc; } iss_exp_t;

   resp_exp_t     resp_q[$];
   iss_exp_t      iss_q[$];
   logic [DW-1:0] tmem [NT][128];
   logic [DW-1:0] rmem [NT][128];
   logic [NT-1:0] hist_en [LAT+1];
   logic [AW-1:0] hist_a  [LAT+1];

   int vecs = 0, errs = 0, cyc = 0, next_ok = 0, exp_err = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Address windows written as plain ranges; first listed window wins.
   function automatic int ref_decode(input logic [AW-1:0] a);
      int lo[NT] = '{'h00, 'h40, 'h60, 'h70};
      int hi[NT] = '{'h3F, 'h5F, 'h6F, 'h7F};
      for (int i = 0; i < NT; i++)
         if (int'(a) >= lo[i] && int'(a) <= hi[i]) return i;
      return -1;
   endfunction

   // Register targets: writes land on the strobe, read data appears exactly LAT cycles after it.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = LAT; i > 0; i--) begin
            hist_en[i] = hist_en[i-1];
            hist_a[i]  = hist_a[i-1];
         end
         hist_en[0] = tgt_en;
         hist_a[0]  = tgt_addr;
         for (int t = 0; t < NT; t++) begin
            if (tgt_en[t] === 1'b1 && tgt_wr_en === 1'b1) tmem[t][tgt_addr] = tgt_wdata;
            tgt_rdata[t*DW +: DW] = $urandom;
            if (hist_en[LAT][t] === 1'b1) tgt_rdata[t*DW +: DW] = tmem[t][hist_a[LAT]];
         end
      end
   end

   initial begin : monitor
      resp_exp_t re;
      iss_exp_t  ie;
      forever begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            vecs++;
            if (resp_q.size() == 0) begin
               errs++;
               $display("FAIL resp_unexpected: got response err=%0b rdata=%0h, expected none (cycle %0d)", resp_err, resp_rdata, cyc);
            end else begin
               re = resp_q.pop_front();
               chk("resp_err", resp_err, re.err);
               chk("resp_rdata", resp_rdata, re.rdata);
               chk("resp_cycle", cyc, re.cyc);
            end
         end
         if (tgt_en != '0) begin
            vecs++;
            if (iss_q.size() == 0) begin
               errs++;
               $display("FAIL tgt_en_unexpected: got %b, expected none (cycle %0d)", tgt_en, cyc);
            end else begin
               ie = iss_q.pop_front();
               chk("tgt_en", tgt_en, ie.en);
               chk("tgt_wr_en", tgt_wr_en, ie.wr);
               chk("tgt_addr", tgt_addr, ie.addr);
               chk("tgt_wdata", tgt_wdata, ie.wdata);
               chk("tgt_en_cycle", cyc, ie.cyc);
            end
         end
      end
   end

   task automatic step(input bit v, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [NT-1:0] en, input bit clr, output bit acc);
      int t;
      bit err_ev;
      @(negedge clk);
      chk("req_ready", req_ready, cyc >= next_ok);
      chk("err_cnt", err_cnt, exp_err);
      req_valid = v; req_wr = wr; req_addr = a; req_wdata = d; tgt_enable = en; err_cnt_clr = clr;
      acc = v && (cyc >= next_ok);
      err_ev = 1'b0;
      if (acc) begin
         t = ref_decode(a);
         if (t < 0 || !en[t]) begin
            resp_q.push_back('{1'b1, '0, cyc + 1});
            next_ok = cyc + 2;
            err_ev = 1'b1;
         end else begin
            iss_q.push_back('{NT'(1) << t, wr, a, d, cyc + 1});
            if (wr) begin
               rmem[t][a] = d;
               resp_q.push_back('{1'b0, '0, cyc + 2});
               next_ok = cyc + 3;
            end else begin
               resp_q.push_back('{1'b0, rmem[t][a], cyc + 2 + LAT});
               next_ok = cyc + 3 + LAT;
            end
         end
      end
      if (clr) exp_err = 0;
      else if (err_ev && exp_err < 255) exp_err++;
   endtask

   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NT-1:0] en, input bit clr);
      bit acc = 1'b0;
      int n = 0;
      while (!acc && n < 20) begin
         step(1'b1, wr, a, d, en, clr, acc);
         n++;
      end
      chk("accept_within_budget", acc, 1'b1);
   endtask

   initial begin : stim
      bit            acc;
      logic [DW-1:0] r;
      int            n_resp, n_low, rv_at, n_stray;

      rst = 1'b1; rst_b = 1'b1; req_valid = 1'b0; req_valid_b = 1'b0; req_wr = 1'b0;
      req_addr = '0; req_wdata = '0; tgt_enable = '0; err_cnt_clr = 1'b0;
      tgt_rdata_b = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
      for (int i = 0; i <= LAT; i++) begin hist_en[i] = '0; hist_a[i] = '0; end
      for (int t = 0; t < NT; t++)
         for (int a = 0; a < 128; a++) begin
            r = $urandom; tmem[t][a] = r; rmem[t][a] = r;
         end
      tmem[1][7'h41] = 32'hDEAD_BEEF;
      rmem[1][7'h41] = 32'hDEAD_BEEF;

      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_tgt_en", tgt_en, 0);
      chk("rst_tgt_addr", tgt_addr, 0);
      chk("rst_err_cnt", err_cnt, 0);
      rst = 1'b0;
      next_ok = cyc + 1;

      issue(1'b0, 7'h41, 32'h0, 4'hF, 1'b0);
      issue(1'b1, 7'h05, 32'h1234_5678, 4'hF, 1'b0);
      issue(1'b0, 7'h62, 32'h0, 4'b1011, 1'b0);
      issue(1'b0, 7'h72, 32'h0, 4'hF, 1'b0);
      issue(1'b0, 7'h05, 32'h0, 4'hF, 1'b0);

      for (int i = 0; i < 300; i++) begin
         issue($urandom_range(0, 1), 7'($urandom), $urandom, 4'($urandom | $urandom), $urandom_range(0, 15) == 0);
         repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 7'($urandom), $urandom, 4'($urandom), $urandom_range(0, 15) == 0, acc);
      end

      for (int i = 0; i < 260; i++) issue(1'b0, 7'h62, 32'h0, 4'b1011, 1'b0);
      step(1'b0, 1'b0, 7'h62, 32'h0, 4'b1011, 1'b0, acc);
      issue(1'b0, 7'h62, 32'h0, 4'b1011, 1'b1);
      repeat (12) step(1'b0, 1'b0, 7'h00, 32'h0, 4'hF, 1'b0, acc);
      chk("resp_queue_drained", resp_q.size(), 0);
      chk("issue_queue_drained", iss_q.size(), 0);

      @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);
      chk("b_ready_after_rst", req_ready_b, 1'b1);
      req_valid_b = 1'b1; req_wr = 1'b0; req_addr = 7'h72; req_wdata = 32'hCAFE_0001; tgt_enable = 4'hF;
      n_resp = 0; n_low = 0; rv_at = -1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) chk("b_priority_tgt_en", tgt_en_b, 4'b0100);
         if (resp_valid_b === 1'b1) begin
            n_resp++;
            rv_at = k;
            chk("b_rdata", resp_rdata_b, 32'h2222_2222);
            chk("b_resp_err", resp_err_b, 1'b0);
         end
         if (k < 7 && req_ready_b !== 1'b1) n_low++;
      end
      chk("b_resp_cycle", rv_at, 6);
      chk("b_resp_count", n_resp, 1);
      chk("b_ready_low_cycles", n_low, LAT_B + 2);
      chk("b_ready_again", req_ready_b, 1'b1);

      @(negedge clk);
      req_valid_b = 1'b0;
      chk("b_second_issue", tgt_en_b, 4'b0100);
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      chk("b_rst_req_ready", req_ready_b, 1'b0);
      chk("b_rst_resp_valid", resp_valid_b, 1'b0);
      chk("b_rst_resp_rdata", resp_rdata_b, 0);
      chk("b_rst_tgt_en", tgt_en_b, 0);
      chk("b_rst_tgt_addr", tgt_addr_b, 0);
      chk("b_rst_tgt_wdata", tgt_wdata_b, 0);
      chk("b_rst_err_cnt", err_cnt_b, 0);
      rst_b = 1'b0;
      @(negedge clk);
      chk("b_ready_post_rst", req_ready_b, 1'b1);
      n_stray = 0;
      repeat (8) begin
         @(negedge clk);
         if (resp_valid_b !== 1'b0 || tgt_en_b !== '0) n_stray++;
      end
      chk("b_no_activity_after_rst", n_stray, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
